// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-compatible interrupt sequencer.
// Optional auto-EOI support elsewhere is enabled with PIC_AUTO_EOI_EN.
package pic_pkg;
  localparam int unsigned NUM_IR  = 8;
  localparam int unsigned LEVEL_W = 3;

  typedef enum logic [1:0] {IDLE, REQ, ACK1, ACK2} pic_state_e;

  // OCW2 R/SL/EOI field encodings
  localparam logic [2:0] OCW2_NS_EOI      = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI      = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS_EOI  = 3'b101;
  localparam logic [2:0] OCW2_ROT_SP_EOI  = 3'b111;
  localparam logic [2:0] OCW2_SET_PRIO    = 3'b110;
  localparam logic [2:0] OCW2_ROT_AEOI_ON = 3'b100;
endpackage

// File: rtl/pic_priority_scan.sv
// Combinational rotating first-set finder: scans vec from start upward,
// wrapping modulo NUM_IR, and reports the first set level.
module pic_priority_scan
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0]  vec,
  input  logic [LEVEL_W-1:0] start,
  output logic               found,
  output logic [LEVEL_W-1:0] level
);

  always_comb begin
    logic [LEVEL_W-1:0] idx;
    found = 1'b0;
    level = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      idx = start + LEVEL_W'(i);
      if (!found && vec[idx]) begin
        found = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8259 sequencing core: priority resolution, INT/INTA handshake, ISR and EOI.
// Define PIC_AUTO_EOI_EN to add the aeoi / aeoi_rotate inputs.
module pic_interrupt_sequencer
  import pic_pkg::*;
#(
  parameter logic [LEVEL_W-1:0] RESET_LOWEST   = 3'd7,
  parameter logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IR-1:0]  irr,
  input  logic               inta_strobe,
  input  logic [4:0]         vector_base,
  input  logic               eoi,
  input  logic               eoi_specific,
  input  logic [LEVEL_W-1:0] eoi_level,
  input  logic               rotate,
  input  logic               set_priority,
`ifdef PIC_AUTO_EOI_EN
  input  logic               aeoi,
  input  logic               aeoi_rotate,
`endif
  output logic               int_out,
  output logic [NUM_IR-1:0]  isr,
  output logic [NUM_IR-1:0]  irr_clear,
  output logic [7:0]         vector_out,
  output logic               vector_valid,
  output logic [LEVEL_W-1:0] lowest_prio
);

  pic_state_e         state_q, state_d;
  logic [NUM_IR-1:0]  isr_q, isr_d;
  logic [NUM_IR-1:0]  irr_clear_q, irr_clear_d;
  logic               int_q, int_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] lowest_q, lowest_d;
`ifdef PIC_AUTO_EOI_EN
  logic               spur_q, spur_d;
`endif

  logic [LEVEL_W-1:0] start;
  logic               irr_found, isr_found, eligible;
  logic [LEVEL_W-1:0] irr_level, isr_level, irr_dist, isr_dist;
  logic [NUM_IR-1:0]  isr_set, eoi_clr, aeoi_clr;
  logic               clr_hit;
  logic [LEVEL_W-1:0] clr_level;

  assign start = lowest_q + 1'b1;

  pic_priority_scan u_irr_scan (
    .vec   (irr),
    .start (start),
    .found (irr_found),
    .level (irr_level)
  );

  pic_priority_scan u_isr_scan (
    .vec   (isr_q),
    .start (start),
    .found (isr_found),
    .level (isr_level)
  );

  // Fully nested: the request must be strictly ahead of every in-service level.
  assign irr_dist = irr_level - start;
  assign isr_dist = isr_level - start;
  assign eligible = irr_found && (!isr_found || (irr_dist < isr_dist));

  always_comb begin
    state_d      = state_q;
    int_d        = 1'b0;
    irr_clear_d  = '0;
    level_d      = level_q;
    lowest_d     = lowest_q;
    isr_set      = '0;
    eoi_clr      = '0;
    aeoi_clr     = '0;
    clr_hit      = 1'b0;
    clr_level    = '0;
    vector_valid = 1'b0;
`ifdef PIC_AUTO_EOI_EN
    spur_d       = spur_q;
`endif

    if (eoi) begin
      if (eoi_specific) begin
        if (isr_q[eoi_level]) begin
          clr_hit   = 1'b1;
          clr_level = eoi_level;
        end
      end else if (isr_found) begin
        clr_hit   = 1'b1;
        clr_level = isr_level;
      end
      if (clr_hit) begin
        eoi_clr[clr_level] = 1'b1;
        if (rotate) lowest_d = clr_level;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d = REQ;
          int_d   = 1'b1;
        end
      end
      REQ: begin
        int_d = 1'b1;
        if (inta_strobe) begin
          state_d = ACK1;
          int_d   = 1'b0;
          if (eligible) begin
            level_d              = irr_level;
            isr_set[irr_level]   = 1'b1;
            irr_clear_d[irr_level] = 1'b1;
`ifdef PIC_AUTO_EOI_EN
            spur_d = 1'b0;
`endif
          end else begin
            level_d = SPURIOUS_LEVEL;
`ifdef PIC_AUTO_EOI_EN
            spur_d = 1'b1;
`endif
          end
        end
      end
      ACK1: begin
        if (inta_strobe) begin
          state_d      = ACK2;
          vector_valid = 1'b1;
`ifdef PIC_AUTO_EOI_EN
          if (aeoi && !spur_q) begin
            aeoi_clr[level_q] = 1'b1;
            if (aeoi_rotate) lowest_d = level_q;
          end
`endif
        end
      end
      ACK2: begin
        vector_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (set_priority) lowest_d = eoi_level;

    // Clears first, then the INTA1 set, so a same-cycle EOI cannot undo it.
    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | isr_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      isr_q       <= '0;
      irr_clear_q <= '0;
      int_q       <= 1'b0;
      level_q     <= '0;
      lowest_q    <= RESET_LOWEST;
`ifdef PIC_AUTO_EOI_EN
      spur_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      isr_q       <= isr_d;
      irr_clear_q <= irr_clear_d;
      int_q       <= int_d;
      level_q     <= level_d;
      lowest_q    <= lowest_d;
`ifdef PIC_AUTO_EOI_EN
      spur_q      <= spur_d;
`endif
    end
  end

  assign int_out     = int_q;
  assign isr         = isr_q;
  assign irr_clear   = irr_clear_q;
  assign lowest_prio = lowest_q;
  assign vector_out  = vector_valid ? {vector_base, level_q} : '0;

endmodule

// File: doc/pic_interrupt_sequencer.md
Name: pic_interrupt_sequencer

Overview:
- Sequencing core of the 8259-compatible PIC. Sits between the request register (IRR) and the data-bus / cascade logic.
- Resolves priority among pending unmasked requests against the in-service register (ISR), using either fixed or rotating priority.
- Raises INT and runs the two-pulse 8086-mode INTA handshake: sets ISR, clears the edge-latched IRR bit and presents the vector byte.
- Clears ISR on EOI commands and maintains the rotating-priority pointer.

Parameters:
- RESET_LOWEST, 3'd7: lowest-priority level after reset, giving fixed order IR0 highest.
- SPURIOUS_LEVEL, 3'd7: level reported when a request vanishes before the first INTA.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- irr  in  8  pending requests from IRR, already masked.
- inta_strobe  in  1  one-cycle pulse per INTA bus cycle, pre-synchronised by control logic.
- vector_base  in  5  ICW2 T7..T3.
- eoi  in  1  one-cycle OCW2 EOI command strobe.
- eoi_specific  in  1  with eoi: 1 = specific EOI using eoi_level, 0 = non-specific.
- eoi_level  in  3  level for specific EOI or set-priority.
- rotate  in  1  with eoi: also rotate (serviced level becomes lowest).
- set_priority  in  1  one-cycle strobe: lowest priority := eoi_level, no ISR change.
- int_out  out  1  INT request to CPU.
- isr  out  8  in-service register.
- irr_clear  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit.
- vector_out  out  8  {vector_base, level}.
- vector_valid  out  1  high while vector_out must be driven (second INTA).
- lowest_prio  out  3  current lowest-priority level.

Behaviour:
- Reset (synchronous, any state, including mid-handshake):
  - state = IDLE, isr = 0, int_out = 0, irr_clear = 0, vector_valid = 0, vector_out = 0, lowest_prio = RESET_LOWEST.
- Priority scan:
  - Combinational. Search starts at lowest_prio+1 (mod 8) and wraps.
  - Candidate = first irr bit set. It is eligible only if it is reached before any set isr bit (fully nested).
  - Level arithmetic is 3-bit wrap-around.
- IDLE:
  - Eligible candidate present -> REQ; int_out goes high the next cycle (1-cycle latency from irr to int_out).
- REQ:
  - int_out = 1.
  - Candidate withdrawn before INTA -> stay REQ with int_out held. The CPU still acknowledges.
  - inta_strobe -> ACK1, and latch the level.
    - Eligible candidate: latch its level, set isr[level], pulse irr_clear[level] for 1 cycle, int_out = 0.
    - No eligible candidate (spurious): latch SPURIOUS_LEVEL, set no isr bit, pulse no irr_clear.
- ACK1:
  - Wait for the second inta_strobe -> ACK2; vector_out = {vector_base, latched level}, vector_valid = 1 for exactly that cycle plus the next.
- ACK2:
  - vector_valid drops -> IDLE.
  - A new eligible request is re-evaluated in IDLE, never directly.
- EOI (accepted in any state, applied the same cycle as the strobe):
  - Non-specific: clear the highest-priority set isr bit (scan order from lowest_prio+1).
  - Specific: clear isr[eoi_level].
  - rotate=1: lowest_prio := the cleared level. If no bit was cleared, lowest_prio is unchanged.
- set_priority:
  - lowest_prio := eoi_level.
  - If it coincides with an eoi strobe, set_priority wins for lowest_prio; the ISR clear still happens.
- Simultaneous EOI and first INTA:
  - The ISR clear is applied first, then the ISR set.
  - Eligibility uses the pre-EOI isr.
- inta_strobe while in IDLE: ignored.
- Extra strobes in ACK2: ignored.

Optional Feature:
- Macro: PIC_AUTO_EOI_EN.
- Defined:
  - Adds input aeoi (ICW4 AEOI bit) and input aeoi_rotate.
  - When aeoi=1, the isr bit set at the first INTA is cleared on the cycle ACK2 is entered.
  - If aeoi_rotate=1, lowest_prio := that level.
- Undefined:
  - Ports absent; ISR cleared only by EOI.

Decomposition:
- Shared package pic_pkg:
  - state enum (IDLE, REQ, ACK1, ACK2);
  - NUM_IR = 8, LEVEL_W = 3;
  - OCW2 EOI field constants.
- Sub-module pic_priority_scan:
  - Combinational rotating first-set finder.
  - Inputs: 8-bit vector, start pointer. Outputs: found and level.
  - Instantiated twice: once for irr, once for isr (non-specific EOI and nesting check).

Test Plan:
- Fixed priority: irr=8'b0010_0100, isr=0 -> int_out=1 next cycle; INTA1 -> isr=8'h04, irr_clear=8'h04; INTA2 with vector_base=5'h11 -> vector_out=8'h8A, vector_valid=1.
- Nesting: isr=8'h04 in service, irr=8'h20 -> int_out stays 0; irr=8'h01 -> INT; second service -> isr=8'h05; non-specific EOI -> isr=8'h04.
- Rotation: service IR3, EOI with rotate=1 -> lowest_prio=3; irr=8'h81 -> IR7 granted first (vector level 7).
- Spurious: IR2 raises INT then drops before INTA1 -> no isr bit set, irr_clear=0, vector level 7.
- Reset in ACK1: reset high for 1 cycle -> state IDLE, isr=0, int_out=0, vector_valid=0, lowest_prio=7.
- AEOI (PIC_AUTO_EOI_EN, aeoi=1): IR4 serviced -> isr[4] set at INTA1 and cleared on ACK2 entry; isr=0 afterwards with no EOI strobe.
